major_cycle_sequencer: RTL

//  Timing generator feeding the instruction-fetch phase decoder and the execute logic.

---
 rtl/major_cycle_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/major_cycle_sequencer.sv
// major_cycle_sequencer
//   Major-cycle timing generator for the fetch phase decoder and execute logic.
//   Walks HALT / FETCH / AUTO1 / AUTO2 / IND / EXEC(k), each non-HALT cycle lasting
//   TICKS clocks, and decodes the ck*/stb* phase outputs from the state, tick and
//   exec-step flops only. No output depends combinationally on any input.
//   Optional build macro SINGLE_STEP_EN adds a 'step' input; a rising edge on it
//   while halted with run=0 runs exactly one instruction.
//
//   state  | meaning
//   HALT   | idle, all phases low, running=0
//   FETCH  | instruction fetch (IR load on stbFetchA, PC increment on stbFetchB)
//   AUTO1  | autoincrement cycle 1 (indirect via 010-017)
//   AUTO2  | autoincrement cycle 2
//   IND    | indirect address cycle
//   EXEC   | execute step k, k = 0..EXEC_STEPS-1

module major_cycle_sequencer #(
  parameter int TICKS      = 4,
  parameter int EXEC_STEPS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  instIsIND,
  input  logic                  instIsPPIND,
  input  logic                  execDone,
`ifdef SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic                  ckFetch,
  output logic                  stbFetchA,
  output logic                  stbFetchB,
  output logic                  ckAuto1,
  output logic                  stbAuto1,
  output logic                  ckAuto2,
  output logic                  stbAuto2,
  output logic                  ckInd,
  output logic                  stbInd,
  output logic [EXEC_STEPS-1:0] ckExec,
  output logic [EXEC_STEPS-1:0] stbExec,
  output logic                  running
);

  localparam int TW = $clog2(TICKS);
  localparam int KW = (EXEC_STEPS > 1) ? $clog2(EXEC_STEPS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
  localparam logic [TW-1:0] TICK_STB  = TW'(TICKS - 2);
  localparam logic [KW-1:0] K_LAST    = KW'(EXEC_STEPS - 1);

  localparam logic [2:0] S_HALT  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_AUTO1 = 3'd2;
  localparam logic [2:0] S_AUTO2 = 3'd3;
  localparam logic [2:0] S_IND   = 3'd4;
  localparam logic [2:0] S_EXEC  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [KW-1:0] k_q, k_d;
  logic          tick_last;
  logic          start;

`ifdef SINGLE_STEP_EN
  logic step_q;

  // Step edge detector; resets to 1 so a step held high through reset is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_q <= 1'b1;
    else       step_q <= step;
  end

  assign start = run | (step & ~step_q);
`else
  assign start = run;
`endif

  assign tick_last = (tick_q == TICK_LAST);

  // Next-state, tick and exec-step selection; decisions only at the last tick of a cycle.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    k_d     = k_q;
    if (state_q == S_HALT) begin
      tick_d = '0;
      k_d    = '0;
      if (start) state_d = S_FETCH;
    end else begin
      tick_d = tick_last ? '0 : tick_q + TW'(1);
      if (tick_last) begin
        case (state_q)
          S_FETCH: begin
            k_d = '0;
            if (instIsPPIND)    state_d = S_AUTO1;
            else if (instIsIND) state_d = S_IND;
            else                state_d = S_EXEC;
          end
          S_AUTO1: state_d = S_AUTO2;
          S_AUTO2: state_d = S_IND;
          S_IND: begin
            state_d = S_EXEC;
            k_d     = '0;
          end
          S_EXEC: begin
            if (execDone || (k_q == K_LAST)) begin
              // Instruction boundary: the only place run is honoured for halting.
              state_d = run ? S_FETCH : S_HALT;
              k_d     = '0;
            end else begin
              k_d = k_q + KW'(1);
            end
          end
          default: state_d = S_HALT;
        endcase
      end
    end
  end

  // State, tick and exec-step registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HALT;
      tick_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      k_q     <= k_d;
    end
  end

  logic                  at_stb;
  logic [EXEC_STEPS-1:0] k_onehot;

  assign at_stb   = (tick_q == TICK_STB);
  assign k_onehot = EXEC_STEPS'(1) << k_q;

  // Phase decode from flops only; reset forces HALT, so every output drops at once.
  always_comb begin
    ckFetch   = (state_q == S_FETCH);
    stbFetchA = (state_q == S_FETCH) && at_stb;
    stbFetchB = (state_q == S_FETCH) && tick_last;
    ckAuto1   = (state_q == S_AUTO1);
    stbAuto1  = (state_q == S_AUTO1) && at_stb;
    ckAuto2   = (state_q == S_AUTO2);
    stbAuto2  = (state_q == S_AUTO2) && at_stb;
    ckInd     = (state_q == S_IND);
    stbInd    = (state_q == S_IND) && at_stb;
    ckExec    = (state_q == S_EXEC) ? k_onehot : '0;
    stbExec   = ((state_q == S_EXEC) && at_stb) ? k_onehot : '0;
    running   = (state_q != S_HALT);
  end

endmodule
